// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the M-extension execute unit: operation codes,
// divider state encoding and operation-class helpers.
package muldiv_unit_pkg;

    localparam logic [5:0] ALU_MUL    = 6'h10;
    localparam logic [5:0] ALU_MULH   = 6'h11;
    localparam logic [5:0] ALU_MULHSU = 6'h12;
    localparam logic [5:0] ALU_MULHU  = 6'h13;
    localparam logic [5:0] ALU_DIV    = 6'h14;
    localparam logic [5:0] ALU_DIVU   = 6'h15;
    localparam logic [5:0] ALU_REM    = 6'h16;
    localparam logic [5:0] ALU_REMU   = 6'h17;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

    function automatic logic is_div_op(input logic [5:0] code);
        return code inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic logic is_mul_op(input logic [5:0] code);
        return code inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

endpackage

// File: rtl/muldiv_unit_divider.sv
// Iterative radix-2 restoring divider with early-out for divide-by-zero
// and signed overflow; holds its result in DONE until granted the output.
module muldiv_divider
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic             is_signed,
    input  logic             is_rem,
    input  logic [XLEN-1:0]  op1,
    input  logic [XLEN-1:0]  op2,
    input  logic [TAG_W-1:0] tag,
    input  logic             grant,
    output logic             can_start,
    output logic             done,
    output logic             busy,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [XLEN-1:0]  quo_reg, quo_next, rem_reg, rem_next;
    logic [XLEN-1:0]  dvs_reg, dvs_next, res_reg, res_next;
    logic             neg_q_reg, neg_q_next, neg_r_reg, neg_r_next;
    logic             is_rem_reg, is_rem_next;
    logic [TAG_W-1:0] tag_reg, tag_next;
    logic [XLEN:0]    trial;
    logic [XLEN-1:0]  quo_fix, rem_fix;

    assign done      = (state_reg == DIV_DONE);
    assign busy      = (state_reg != DIV_IDLE);
    // A new op may enter on the same edge the held result leaves DONE.
    assign can_start = (state_reg == DIV_IDLE) || (done && grant);
    assign result    = res_reg;
    assign tag_out   = tag_reg;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        quo_next    = quo_reg;
        rem_next    = rem_reg;
        dvs_next    = dvs_reg;
        res_next    = res_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        is_rem_next = is_rem_reg;
        tag_next    = tag_reg;
        trial       = {rem_reg, quo_reg[XLEN-1]};
        quo_fix     = neg_q_reg ? -quo_reg : quo_reg;
        rem_fix     = neg_r_reg ? -rem_reg : rem_reg;

        case (state_reg)
            DIV_CALC: begin
                if (trial >= {1'b0, dvs_reg}) begin
                    rem_next = trial[XLEN-1:0] - dvs_reg;
                    quo_next = {quo_reg[XLEN-2:0], 1'b1};
                end else begin
                    rem_next = trial[XLEN-1:0];
                    quo_next = {quo_reg[XLEN-2:0], 1'b0};
                end
                if (cnt_reg == CNT_W'(XLEN-1)) begin
                    cnt_next   = '0;
                    state_next = DIV_FIX;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DIV_FIX: begin
                res_next   = is_rem_reg ? rem_fix : quo_fix;
                state_next = DIV_DONE;
            end
            DIV_DONE: begin
                if (grant) state_next = DIV_IDLE;
            end
            default: ;
        endcase

        if (start && can_start) begin
            tag_next    = tag;
            is_rem_next = is_rem;
            cnt_next    = '0;
            if (op2 == '0) begin
                res_next   = is_rem ? op1 : '1;
                state_next = DIV_DONE;
            end else if (is_signed && op1 == MOST_NEG && op2 == '1) begin
                res_next   = is_rem ? '0 : op1;
                state_next = DIV_DONE;
            end else begin
                quo_next   = (is_signed && op1[XLEN-1]) ? -op1 : op1;
                dvs_next   = (is_signed && op2[XLEN-1]) ? -op2 : op2;
                rem_next   = '0;
                neg_q_next = is_signed && (op1[XLEN-1] ^ op2[XLEN-1]);
                neg_r_next = is_signed && op1[XLEN-1];
                state_next = DIV_CALC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_reg <= DIV_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_reg <= '0;
            tag_reg <= '0;
        end else begin
            res_reg <= res_next;
            tag_reg <= tag_next;
        end
        quo_reg    <= quo_next;
        rem_reg    <= rem_next;
        dvs_reg    <= dvs_next;
        neg_q_reg  <= neg_q_next;
        neg_r_reg  <= neg_r_next;
        is_rem_reg <= is_rem_next;
    end

endmodule

// File: rtl/muldiv_unit.sv
// M-extension execute unit: pipelined multiplier, iterative divider and a
// result arbiter that favours the multiplier's last stage.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 3,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       alucode,
    input  logic [XLEN-1:0]  op1,
    input  logic [XLEN-1:0]  op2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             div_busy
);

    localparam int LAST = MUL_STAGES - 1;

    logic [MUL_STAGES-1:0] mul_valid_reg;
    logic [MUL_STAGES-1:0] mul_hi_reg;
    logic [TAG_W-1:0]      mul_tag_reg  [MUL_STAGES];
    logic [2*XLEN-1:0]     mul_prod_reg [MUL_STAGES];

    logic              is_div, accept, sign1, sign2;
    logic [2*XLEN-1:0] a_wide, b_wide, prod_in;
    logic              div_can_start, div_done, div_grant;
    logic [XLEN-1:0]   div_result;
    logic [TAG_W-1:0]  div_tag;

    assign is_div    = is_div_op(alucode);
    assign div_grant = div_done && !mul_valid_reg[LAST];
    // Mul issue stalls while a finished divide is waiting behind live mul ops,
    // so the divider is guaranteed a free output slot.
    assign in_ready  = !(rst || flush) &&
                       (is_div ? div_can_start : !(div_done && (|mul_valid_reg)));
    assign accept    = in_valid && in_ready;

    // Sign-extending into 2*XLEN bits gives the exact low 2*XLEN product bits.
    assign sign1   = (alucode == ALU_MULH || alucode == ALU_MULHSU) && op1[XLEN-1];
    assign sign2   = (alucode == ALU_MULH) && op2[XLEN-1];
    assign a_wide  = {{XLEN{sign1}}, op1};
    assign b_wide  = {{XLEN{sign2}}, op2};
    assign prod_in = is_mul_op(alucode) ? a_wide * b_wide : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) mul_valid_reg[0] <= 1'b0;
        else              mul_valid_reg[0] <= accept && !is_div;
        mul_hi_reg[0]   <= (alucode != ALU_MUL);
        mul_tag_reg[0]  <= in_tag;
        mul_prod_reg[0] <= prod_in;
    end

    generate
        for (genvar gi = 1; gi < MUL_STAGES; gi++) begin : g_mul_stage
            always_ff @(posedge clk) begin
                if (rst || flush) mul_valid_reg[gi] <= 1'b0;
                else              mul_valid_reg[gi] <= mul_valid_reg[gi-1];
                mul_hi_reg[gi]   <= mul_hi_reg[gi-1];
                mul_tag_reg[gi]  <= mul_tag_reg[gi-1];
                mul_prod_reg[gi] <= mul_prod_reg[gi-1];
            end
        end
    endgenerate

    muldiv_divider #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .start     (accept && is_div),
        .is_signed (alucode == ALU_DIV || alucode == ALU_REM),
        .is_rem    (alucode == ALU_REM || alucode == ALU_REMU),
        .op1       (op1),
        .op2       (op2),
        .tag       (in_tag),
        .grant     (div_grant),
        .can_start (div_can_start),
        .done      (div_done),
        .busy      (div_busy),
        .result    (div_result),
        .tag_out   (div_tag)
    );

    always_comb begin
        out_valid = mul_valid_reg[LAST] || div_done;
        result    = '0;
        out_tag   = '0;
        if (mul_valid_reg[LAST]) begin
            result  = mul_hi_reg[LAST] ? mul_prod_reg[LAST][2*XLEN-1:XLEN]
                                       : mul_prod_reg[LAST][XLEN-1:0];
            out_tag = mul_tag_reg[LAST];
        end else if (div_done) begin
            result  = div_result;
            out_tag = div_tag;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32, MUL_STAGES=3, TAG_W=5).
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [5:0]  alucode = ALU_MUL;
    logic [31:0] op1 = '0, op2 = '0;
    logic [4:0]  in_tag = '0;
    logic        in_ready, out_valid, div_busy;
    logic [31:0] result;
    logic [4:0]  out_tag;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    int          q_cyc [$];
    logic [4:0]  q_tag [$];
    logic [31:0] q_res [$];

    muldiv_unit #(.XLEN(32), .MUL_STAGES(3), .TAG_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alucode   (alucode),
        .op1       (op1),
        .op2       (op2),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .result    (result),
        .out_tag   (out_tag),
        .div_busy  (div_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Cycle c is the interval after the c-th rising edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            q_cyc.push_back(cyc);
            q_tag.push_back(out_tag);
            q_res.push_back(result);
            $display("out  cyc=%0d tag=%0d result=%h", cyc, out_tag, result);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Presents an op starting now (just after a rising edge) and holds it
    // until accepted; acc is the number of the accepting edge.
    task automatic issue(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output int acc);
        alucode = code; op1 = a; op2 = b; in_tag = tag; in_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                acc = cyc + 1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        $display("issue code=%h op1=%h op2=%h tag=%0d acc=%0d", code, a, b, tag, acc);
        if (acc < 0) begin
            n_vec++; n_bad++;
            $display("FAIL issue_timeout: tag=%0d never accepted, required acceptance", tag);
        end
    endtask

    task automatic wait_results(input int n);
        for (int i = 0; i < 300 && q_cyc.size() < n; i++) @(posedge clk);
        #1;
        if (q_cyc.size() < n) begin
            n_vec++; n_bad++;
            $display("FAIL result_timeout: got %0d results, required %0d", q_cyc.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; alucode = ALU_DIV;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_in_ready: in_ready=%b required 0", in_ready);
        end
        n_vec++;
        if ({out_valid, result, out_tag, div_busy} !== 39'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: out_valid=%b result=%h tag=%0d div_busy=%b required all 0",
                     out_valid, result, out_tag, div_busy);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_in_ready: in_ready=%b required 1", in_ready);
        end
        $display("reset done");
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        int acc, base;
        base = q_cyc.size();
        issue(ALU_MUL, 32'd7, 32'hFFFF_FFFD, 5'd4, acc);
        wait_results(base + 1);
        n_vec++;
        if (q_res[base] !== 32'hFFFF_FFEB || q_tag[base] !== 5'd4 || q_cyc[base] !== acc + 2) begin
            n_bad++;
            $display("FAIL mul_basic: result=%h tag=%0d cyc=%0d required %h tag 4 cyc %0d",
                     q_res[base], q_tag[base], q_cyc[base], 32'hFFFF_FFEB, acc + 2);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  codes [3] = '{ALU_MULH, ALU_MULHU, ALU_MULHSU};
        logic [31:0] av    [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bv    [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ev    [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        int acc [3];
        int base;
        base = q_cyc.size();
        for (int k = 0; k < 3; k++) issue(codes[k], av[k], bv[k], 5'(5 + k), acc[k]);
        n_vec++;
        if (acc[1] !== acc[0] + 1 || acc[2] !== acc[0] + 2) begin
            n_bad++;
            $display("FAIL b2b_accept: acc=%0d,%0d,%0d required consecutive", acc[0], acc[1], acc[2]);
        end
        wait_results(base + 3);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (q_res[base+k] !== ev[k] || q_tag[base+k] !== 5'(5 + k) || q_cyc[base+k] !== acc[0] + 2 + k) begin
                n_bad++;
                $display("FAIL b2b_result%0d: result=%h tag=%0d cyc=%0d required %h tag %0d cyc %0d",
                         k, q_res[base+k], q_tag[base+k], q_cyc[base+k], ev[k], 5 + k, acc[0] + 2 + k);
            end
        end
    endtask

    task automatic test_div_corner();
        logic [5:0]  codes [8] = '{ALU_DIV, ALU_REM, ALU_DIVU, ALU_REM, ALU_DIV, ALU_REM, ALU_REMU, ALU_DIVU};
        logic [31:0] av    [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd1234, 32'd5,
                                   32'h8000_0000, 32'h8000_0000, 32'd100, 32'hFFFF_FFFF};
        logic [31:0] bv    [8] = '{32'd2, 32'd2, 32'd0, 32'd0,
                                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd1};
        logic [31:0] ev    [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,
                                   32'h8000_0000, 32'd0, 32'd2, 32'hFFFF_FFFF};
        int          lat   [8] = '{34, 34, 1, 1, 1, 1, 34, 34};
        int acc, base;
        for (int k = 0; k < 8; k++) begin
            base = q_cyc.size();
            issue(codes[k], av[k], bv[k], 5'(8 + k), acc);
            wait_results(base + 1);
            n_vec++;
            if (q_res[base] !== ev[k] || q_tag[base] !== 5'(8 + k) || q_cyc[base] !== acc + lat[k] - 1) begin
                n_bad++;
                $display("FAIL div_case%0d: result=%h tag=%0d latency=%0d required %h tag %0d latency %0d",
                         k, q_res[base], q_tag[base], q_cyc[base] - acc + 1, ev[k], 8 + k, lat[k]);
            end
        end
    endtask

    task automatic test_div_mul_order();
        int ad, am, ad2, base;
        base = q_cyc.size();
        issue(ALU_DIV, 32'd100, 32'd7, 5'd1, ad);
        issue(ALU_MUL, 32'd3, 32'd5, 5'd2, am);
        alucode = ALU_DIV; op1 = 32'd50; op2 = 32'd5; in_tag = 5'd3; in_valid = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0 || div_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL div_holdoff: in_ready=%b div_busy=%b required 0 and 1", in_ready, div_busy);
        end
        issue(ALU_DIV, 32'd50, 32'd5, 5'd3, ad2);
        wait_results(base + 3);
        n_vec++;
        if (q_res[base] !== 32'd15 || q_tag[base] !== 5'd2 || q_cyc[base] !== am + 2) begin
            n_bad++;
            $display("FAIL order_mul: result=%h tag=%0d cyc=%0d required 0000000f tag 2 cyc %0d",
                     q_res[base], q_tag[base], q_cyc[base], am + 2);
        end
        n_vec++;
        if (q_res[base+1] !== 32'd14 || q_tag[base+1] !== 5'd1 || q_cyc[base+1] !== ad + 33) begin
            n_bad++;
            $display("FAIL order_div: result=%h tag=%0d cyc=%0d required 0000000e tag 1 cyc %0d",
                     q_res[base+1], q_tag[base+1], q_cyc[base+1], ad + 33);
        end
        n_vec++;
        if (ad2 !== ad + 34) begin
            n_bad++;
            $display("FAIL div_reissue: accepted at %0d required %0d", ad2, ad + 34);
        end
        n_vec++;
        if (q_res[base+2] !== 32'd10 || q_tag[base+2] !== 5'd3 || q_cyc[base+2] !== ad2 + 33) begin
            n_bad++;
            $display("FAIL order_div2: result=%h tag=%0d cyc=%0d required 0000000a tag 3 cyc %0d",
                     q_res[base+2], q_tag[base+2], q_cyc[base+2], ad2 + 33);
        end
    endtask

    task automatic test_collision();
        int ad, am, am2, base;
        base = q_cyc.size();
        issue(ALU_DIVU, 32'd1000, 32'd3, 5'd20, ad);
        repeat (30) @(posedge clk);
        #1;
        issue(ALU_MUL, 32'd6, 32'd7, 5'd21, am);
        n_vec++;
        if (am !== ad + 31) begin
            n_bad++;
            $display("FAIL coll_setup: mul accepted at %0d required %0d", am, ad + 31);
        end
        repeat (2) @(posedge clk);
        #1;
        alucode = ALU_MUL; op1 = 32'd2; op2 = 32'd2; in_tag = 5'd22; in_valid = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL coll_mul_stall: in_ready=%b required 0", in_ready);
        end
        issue(ALU_MUL, 32'd2, 32'd2, 5'd22, am2);
        wait_results(base + 3);
        n_vec++;
        if (q_res[base] !== 32'd42 || q_tag[base] !== 5'd21 || q_cyc[base] !== ad + 33) begin
            n_bad++;
            $display("FAIL coll_mul_first: result=%h tag=%0d cyc=%0d required 0000002a tag 21 cyc %0d",
                     q_res[base], q_tag[base], q_cyc[base], ad + 33);
        end
        n_vec++;
        if (q_res[base+1] !== 32'd333 || q_tag[base+1] !== 5'd20 || q_cyc[base+1] !== ad + 34) begin
            n_bad++;
            $display("FAIL coll_div_next: result=%h tag=%0d cyc=%0d required 0000014d tag 20 cyc %0d",
                     q_res[base+1], q_tag[base+1], q_cyc[base+1], ad + 34);
        end
        n_vec++;
        if (am2 !== ad + 35 || q_res[base+2] !== 32'd4 || q_tag[base+2] !== 5'd22 || q_cyc[base+2] !== ad + 37) begin
            n_bad++;
            $display("FAIL coll_mul_after: acc=%0d result=%h tag=%0d cyc=%0d required acc %0d 00000004 tag 22 cyc %0d",
                     am2, q_res[base+2], q_tag[base+2], q_cyc[base+2], ad + 35, ad + 37);
        end
    endtask

    task automatic test_abort(input bit use_rst, input logic [4:0] t0);
        int ad, am, a2, base;
        base = q_cyc.size();
        issue(ALU_DIVU, 32'd1000, 32'd3, t0, ad);
        repeat (4) @(posedge clk);
        #1;
        issue(ALU_MUL, 32'd9, 32'd9, t0 + 5'd1, am);
        issue(ALU_MUL, 32'd8, 32'd8, t0 + 5'd2, am);
        alucode = ALU_MUL; op1 = 32'd1; op2 = 32'd1; in_tag = t0 + 5'd3; in_valid = 1'b1;
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_in_ready(rst=%0d): in_ready=%b required 0", use_rst, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (div_busy !== 1'b0 || out_valid !== 1'b0 || result !== 32'd0) begin
            n_bad++;
            $display("FAIL abort_state(rst=%0d): div_busy=%b out_valid=%b result=%h required 0 0 0",
                     use_rst, div_busy, out_valid, result);
        end
        repeat (50) @(posedge clk);
        #1;
        n_vec++;
        if (q_cyc.size() !== base) begin
            n_bad++;
            $display("FAIL abort_no_output(rst=%0d): %0d results seen, required 0", use_rst, q_cyc.size() - base);
        end
        issue(ALU_DIV, 32'd100, 32'd7, t0 + 5'd4, a2);
        wait_results(base + 1);
        n_vec++;
        if (q_res[base] !== 32'd14 || q_tag[base] !== t0 + 5'd4 || q_cyc[base] !== a2 + 33) begin
            n_bad++;
            $display("FAIL abort_recover(rst=%0d): result=%h tag=%0d cyc=%0d required 0000000e tag %0d cyc %0d",
                     use_rst, q_res[base], q_tag[base], q_cyc[base], t0 + 5'd4, a2 + 33);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_back_to_back();
        test_div_corner();
        test_div_mul_order();
        test_collision();
        test_abort(1'b0, 5'd24);
        test_abort(1'b1, 5'd16);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised M-extension execute unit that replaces the fixed six-stage, unhandshaked multiclock ALU. It has a fully pipelined multiplier with configurable depth and an iterative radix-2 divider with early-out for special operands. Issue uses a valid/ready handshake, each operation carries a destination tag, and a flush is supported. It sits beside the single-cycle ALU in the execute stage and returns results to writeback, possibly out of order, identified by tag.

## Interface
- XLEN, 32: operand/result width (≥8, even)
- MUL_STAGES, 3: multiplier latency in cycles (≥1)
- TAG_W, 5: width of destination tag carried with each op
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  issue request
- in_ready  out  1  unit can accept the op presented this cycle
- alucode  in  6  ALU_MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; other codes are illegal
- op1, op2  in  XLEN  operands (rs1, rs2)
- in_tag  in  TAG_W  destination tag
- flush  in  1  discard every in-flight and pending op
- out_valid  out  1  result valid for exactly one cycle (no backpressure; writeback always accepts)
- result  out  XLEN  result; 0 when out_valid=0
- out_tag  out  TAG_W  tag of the result
- div_busy  out  1  divider occupied (in progress or result pending)

## Operation
- Accept = in_valid & in_ready at a rising edge. An illegal alucode that is accepted produces result 0 via the multiplier path.
- Multiplier path:
  - Operands are extended to XLEN+1 bits: signed for MULH/MULH(SU op1), unsigned otherwise.
  - The 2·XLEN product advances through MUL_STAGES registers, each with valid, tag and a high/low select.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
  - One op can be accepted per cycle.
- Divider path (sub-module): FSM states IDLE → CALC → FIX → DONE.
  - IDLE, on accept:
    - op2==0: quotient all-ones, remainder op1; go to DONE directly.
    - Signed, op1==most-negative and op2==−1: quotient op1, remainder 0; go to DONE directly.
    - Otherwise latch |op1|, |op2| and the sign flags, then go to CALC.
  - CALC: XLEN restoring shift/subtract iterations, one per cycle, with a counter running 0..XLEN−1.
  - FIX: apply sign correction. Quotient is negated if the operand signs differ; remainder takes the sign of op1.
  - DONE: hold the result until granted the output, then go to IDLE.
- Output arbitration:
  - The multiplier's last stage has priority.
  - A divider result in DONE is emitted in the first cycle with no multiplier output.
- in_ready:
  - Div ops: in_ready = divider in IDLE.
  - Mul ops: in_ready = !(divider in DONE & the multiplier pipe holds any valid op). This guarantees the divider drains.
  - in_ready = 0 while rst or flush is asserted.
- flush: all multiplier stage valids clear, the divider returns to IDLE, and out_valid=0 from the next cycle.

## Timing
- Reset: all stage valids 0, divider IDLE, counter 0; out_valid=0, result=0, out_tag=0, div_busy=0; in_ready=1 from the first cycle after rst deasserts.
- Mul accepted at edge N: out_valid high in the cycle following edge N+MUL_STAGES−1, i.e. latency MUL_STAGES. Throughput is 1 per cycle.
- Div, normal operands: latency XLEN+2 (1 setup + XLEN iterations + 1 fix), plus any arbitration stall.
- Div, special case: latency 1 plus stall.
- Next div op can be accepted at the edge where the divider goes DONE→IDLE, i.e. back-to-back issue is possible in that same cycle.
- Simultaneous flush and accept: flush wins and the op is dropped.
- Simultaneous rst and flush: behaves as reset.
- Reset or flush mid-CALC: the divider abandons the op, no result is produced, and the counter is cleared.
- Mul and div finishing in the same cycle: the mul result is emitted, the div result is held, and the div result is emitted next free cycle.

## Structure
- Shared package/define file holds:
  - alucode constants (ALU_MUL..ALU_REMU)
  - divider state encoding (IDLE/CALC/FIX/DONE)
- Sub-module `muldiv_divider`: iterative divider with start/op/operands/tag in and done/grant handshake out.
- The multiplier pipeline and arbiter live in the top level.

## Test plan
- MUL 7×−3 (0xFFFFFFFD), tag 4, XLEN=32, MUL_STAGES=3 → out_valid 3 cycles after accept; result 0xFFFFFFEB, tag 4.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU −1×0xFFFFFFFF → 0xFFFFFFFF. Issue back-to-back and check 1 result per cycle, in order.
- Division corner cases:
  - DIV −7/2 → −3 and REM −7/2 → −1, each with latency 34.
  - DIVU x/0 → 0xFFFFFFFF and REM 5/0 → 5, each with latency 1.
  - DIV 0x80000000/−1 → 0x80000000.
- Issue DIV (tag 1), then MUL (tag 2) on the next cycle → MUL result before DIV. A second DIV is held off (in_ready=0) until the first leaves DONE.
- Collision:
  - Time a MUL so its last stage coincides with divider DONE.
  - Required: MUL result emitted first, DIV result on the next cycle.
  - While DONE is pending with a full multiplier pipe, in_ready=0 for MUL ops.
- Flush mid-CALC and with 2 mul ops in flight → no out_valid afterwards and div_busy=0 next cycle. A new DIV 100/7 then returns 14 with correct timing. Repeat the same sequence using rst.
